alu_share_arbiter: RTL and testbench
====================================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: CNT_W, 16, width of each saturating grant counter (legal 1..32).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  operation of requester n accepted this cycle.
REQ-006 req0_op / req1_op  input  4  ALU opcode of requester n.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  32  left/right operands of requester n.
REQ-008 rsp_valid  output  1  result register holds a result.
REQ-009 rsp_ready  input  1  consumer takes result this cycle.
REQ-010 rsp_id  output  1  requester that owns the result.
REQ-011 rsp_data  output  32  ALU result.
REQ-012 gnt_cnt0 / gnt_cnt1  output  CNT_W  accepted-operation count per requester.

Function
REQ-013 Block SHALL instantiate exactly one Alu32b_simple and time-share it between two requesters.
REQ-014 ALU semantics SHALL be: op[3] inverts A; op[2] inverts B; op[1:0] selects 0 AND, 1 OR, 2 ADD mod 2^32, 3 {31'b0, bit31 of the sum}.
REQ-015 Output stage SHALL be a one-entry register with states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-016 Stage SHALL be open when EMPTY, or when FULL with rsp_ready=1 in the same cycle.
REQ-017 Grant SHALL go to the only valid requester; both valid resolved per REQ-029/REQ-030; none valid means no grant.
REQ-018 reqN_ready SHALL equal (grant to N) AND stage open AND NOT rst; at most one ready high per cycle.
REQ-019 reqN_ready SHALL NOT depend on reqN_ready of the other port or on rsp_data.
REQ-020 Transfer occurs when reqN_valid AND reqN_ready; next edge SHALL load rsp_data=ALU(reqN_op, reqN_a, reqN_b), rsp_id=N, rsp_valid=1 (latency 1 cycle).
REQ-021 Transitions: EMPTY->FULL on transfer; FULL->EMPTY on rsp_ready without transfer; FULL->FULL on rsp_ready with transfer (new result replaces old); FULL held with rsp_ready=0.
REQ-022 rsp_data and rsp_id SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-023 Sustained throughput SHALL be one operation per cycle with rsp_ready held 1.
REQ-024 gnt_cntN SHALL increment by 1 on each transfer from N and saturate at 2^CNT_W-1 (no wrap).
REQ-025 A requester SHALL keep req fields stable until accepted; block does not store unaccepted requests.

Reset
REQ-026 While rst=1 at a clock edge: rsp_valid=0, rsp_id=0, rsp_data=0, gnt_cnt0=gnt_cnt1=0, state EMPTY, round-robin pointer (last-granted) = 1.
REQ-027 While rst=1, req0_ready and req1_ready SHALL be 0; no transfer or count occurs.
REQ-028 Reset asserted while FULL SHALL discard the held result; no response is produced for it.

Configuration
REQ-029 With macro ALU_SHARE_ARBITER_RR_EN defined: both valid -> grant to requester other than the last granted; pointer updates only on transfer.
REQ-030 Without ALU_SHARE_ARBITER_RR_EN: fixed priority, requester 0 always wins; no pointer register exists.

Verification
REQ-031 Reset, then req0 op=0010 a=5 b=7, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=12, gnt_cnt0=1.
REQ-032 req1 op=0111 a=3 b=5 -> rsp_data=1 (3+0xFFFFFFFA=0xFFFFFFFD, bit31=1); op=0001 a=0xF0 b=0x0F -> 0xFF; op=1100 a=0 b=0 -> 0xFFFFFFFF.
REQ-033 Both valid continuously, rsp_ready=1, RR_EN defined -> grants 0,1,0,1...; macro undefined -> grants 0,0,0..., gnt_cnt1 stays 0.
REQ-034 rsp_ready=0 for 3 cycles while FULL -> both readys 0, rsp_data/rsp_id unchanged; rsp_ready=1 with req0 valid -> old result consumed and new one loaded same edge.
REQ-035 Assert rst one cycle while FULL with both valid -> next cycle rsp_valid=0, counters 0, readys 0 during rst; first post-reset grant goes to requester 0.
REQ-036 CNT_W=2, 5 transfers from req0 -> gnt_cnt0 sequence 1,2,3,3,3.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle for alu_share_arbiter: two requester ports and one result port.
// master = requesters/consumer side, slave = arbiter side.
interface alu_share_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two requesters time-share one 32-bit ALU through a one-entry result register.
// Define ALU_SHARE_ARBITER_RR_EN for round-robin arbitration; default is fixed priority (req0 wins).
module Alu32b_simple (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic [31:0] a_eff;
    logic [31:0] b_eff;
    logic [31:0] sum;

    always_comb begin
        a_eff = op[3] ? ~a : a;
        b_eff = op[2] ? ~b : b;
        sum   = a_eff + b_eff;
        case (op[1:0])
            2'd0:    y = a_eff & b_eff;
            2'd1:    y = a_eff | b_eff;
            2'd2:    y = sum;
            default: y = {31'b0, sum[31]};
        endcase
    end
endmodule

module alu_share_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_share_arbiter_if.slave bus,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]  state;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        sel;
    logic        stage_open;
    logic        xfer;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;

`ifdef ALU_SHARE_ARBITER_RR_EN
    logic last_gnt;

    // sel is only meaningful when at least one requester is valid.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid)
            sel = ~last_gnt;
        else
            sel = bus.req1_valid;
    end
`else
    always_comb begin
        sel = ~bus.req0_valid;
    end
`endif

    always_comb begin
        stage_open = (state == ST_EMPTY) || bus.rsp_ready;
        xfer       = (bus.req0_valid || bus.req1_valid) && stage_open && !rst;
        alu_op     = sel ? bus.req1_op : bus.req0_op;
        alu_a      = sel ? bus.req1_a  : bus.req0_a;
        alu_b      = sel ? bus.req1_b  : bus.req0_b;
    end

    Alu32b_simple u_alu (
        .op (alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    assign bus.req0_ready = xfer && !sel;
    assign bus.req1_ready = xfer && sel;
    assign bus.rsp_valid  = (state == ST_FULL);
    assign bus.rsp_id     = rsp_id;
    assign bus.rsp_data   = rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (xfer) begin
            // A new result may replace one being consumed on the same edge.
            state    <= ST_FULL;
            rsp_id   <= sel;
            rsp_data <= alu_y;
            if (!sel && gnt_cnt0 != '1)
                gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
            if (sel && gnt_cnt1 != '1)
                gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
        end else if (bus.rsp_ready) begin
            state <= ST_EMPTY;
        end
    end

`ifdef ALU_SHARE_ARBITER_RR_EN
    always_ff @(posedge clk) begin
        if (rst)
            last_gnt <= 1'b1;
        else if (xfer)
            last_gnt <= sel;
    end
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter; expectations adapt to ALU_SHARE_ARBITER_RR_EN.
module tb_alu_share_arbiter;
    logic clk;
    logic rst;
    logic [15:0] gnt_cnt0;
    logic [15:0] gnt_cnt1;
    logic [1:0]  s_cnt0;
    logic [1:0]  s_cnt1;
    int unsigned n_cmp;
    int unsigned n_err;

    alu_share_arbiter_if bus ();
    alu_share_arbiter_if s_bus ();

    alu_share_arbiter #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1)
    );

    alu_share_arbiter #(.CNT_W(2)) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .bus      (s_bus),
        .gnt_cnt0 (s_cnt0),
        .gnt_cnt1 (s_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic id, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        if (id) begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end
        #1;
        check({tag, "_rdy"}, {31'b0, id ? bus.req1_ready : bus.req0_ready}, 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check({tag, "_vld"}, {31'b0, bus.rsp_valid}, 32'd1);
        check({tag, "_id"}, {31'b0, bus.rsp_id}, {31'b0, id});
        check({tag, "_data"}, bus.rsp_data, exp);
    endtask

    initial begin
        logic        last;
        logic        exp_sel;
        logic [31:0] exp_data;
        int unsigned c0;
        int unsigned c1;
        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready = 1'b0;
        s_bus.req0_valid = 1'b0; s_bus.req0_op = 4'b0010; s_bus.req0_a = 32'd1; s_bus.req0_b = 32'd1;
        s_bus.req1_valid = 1'b0; s_bus.req1_op = '0; s_bus.req1_a = '0; s_bus.req1_b = '0;
        s_bus.rsp_ready = 1'b1;

        // Reset: readys held low even with both requesters valid
        tick();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        check("rst_rdy0", {31'b0, bus.req0_ready}, 32'd0);
        check("rst_rdy1", {31'b0, bus.req1_ready}, 32'd0);
        tick();
        check("rst_vld", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_id", {31'b0, bus.rsp_id}, 32'd0);
        check("rst_data", bus.rsp_data, 32'd0);
        check("rst_cnt0", {16'b0, gnt_cnt0}, 32'd0);
        check("rst_cnt1", {16'b0, gnt_cnt1}, 32'd0);
        check("rst_scnt0", {30'b0, s_cnt0}, 32'd0);
        rst = 1'b0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.rsp_ready = 1'b1;

        // Single ops through each port
        do_op("add5_7", 1'b0, 4'b0010, 32'd5, 32'd7, 32'd12);
        check("add_cnt0", {16'b0, gnt_cnt0}, 32'd1);
        do_op("sign", 1'b1, 4'b0111, 32'd3, 32'd5, 32'd1);
        do_op("or", 1'b1, 4'b0001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
        do_op("nand", 1'b1, 4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFF);
        check("ops_cnt1", {16'b0, gnt_cnt1}, 32'd3);
        c0 = 1; c1 = 3; last = 1'b1;

        // Contention, rsp_ready held high
        bus.req0_op = 4'b0010; bus.req0_a = 32'd1;  bus.req0_b = 32'd1;
        bus.req1_op = 4'b0010; bus.req1_a = 32'd10; bus.req1_b = 32'd10;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        exp_data = 32'd0;
        for (int i = 0; i < 6; i++) begin
`ifdef ALU_SHARE_ARBITER_RR_EN
            exp_sel = ~last;
`else
            exp_sel = 1'b0;
`endif
            #1;
            check("both_rdy0", {31'b0, bus.req0_ready}, {31'b0, ~exp_sel});
            check("both_rdy1", {31'b0, bus.req1_ready}, {31'b0, exp_sel});
            tick();
            exp_data = exp_sel ? 32'd20 : 32'd2;
            check("both_id", {31'b0, bus.rsp_id}, {31'b0, exp_sel});
            check("both_data", bus.rsp_data, exp_data);
            if (exp_sel) c1++; else c0++;
            last = exp_sel;
        end
        check("both_cnt0", {16'b0, gnt_cnt0}, c0);
        check("both_cnt1", {16'b0, gnt_cnt1}, c1);

        // Back-pressure hold, then consume-and-reload on the same edge
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_rdy0", {31'b0, bus.req0_ready}, 32'd0);
            check("hold_rdy1", {31'b0, bus.req1_ready}, 32'd0);
            tick();
            check("hold_vld", {31'b0, bus.rsp_valid}, 32'd1);
            check("hold_id", {31'b0, bus.rsp_id}, {31'b0, last});
            check("hold_data", bus.rsp_data, exp_data);
        end
        bus.req1_valid = 1'b0;
        bus.req0_op = 4'b0000; bus.req0_a = 32'h0000_00FF; bus.req0_b = 32'h0000_000F;
        bus.rsp_ready = 1'b1;
        #1;
        check("repl_rdy0", {31'b0, bus.req0_ready}, 32'd1);
        tick();
        check("repl_vld", {31'b0, bus.rsp_valid}, 32'd1);
        check("repl_id", {31'b0, bus.rsp_id}, 32'd0);
        check("repl_data", bus.rsp_data, 32'h0000_000F);
        c0++;
        check("repl_cnt0", {16'b0, gnt_cnt0}, c0);

        // Reset while FULL with both requesters valid
        bus.req1_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("mrst_rdy0", {31'b0, bus.req0_ready}, 32'd0);
        check("mrst_rdy1", {31'b0, bus.req1_ready}, 32'd0);
        tick();
        rst = 1'b0;
        check("mrst_vld", {31'b0, bus.rsp_valid}, 32'd0);
        check("mrst_data", bus.rsp_data, 32'd0);
        check("mrst_cnt0", {16'b0, gnt_cnt0}, 32'd0);
        check("mrst_cnt1", {16'b0, gnt_cnt1}, 32'd0);
        bus.rsp_ready = 1'b1;
        #1;
        check("post_rdy0", {31'b0, bus.req0_ready}, 32'd1);
        check("post_rdy1", {31'b0, bus.req1_ready}, 32'd0);
        tick();
        check("post_id", {31'b0, bus.rsp_id}, 32'd0);
        check("post_data", bus.rsp_data, 32'h0000_000F);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

        // Saturation with a 2-bit counter
        s_bus.req0_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check("sat_rdy", {31'b0, s_bus.req0_ready}, 32'd1);
            tick();
            check("sat_cnt0", {30'b0, s_cnt0}, (i > 3) ? 32'd3 : 32'(i));
        end
        s_bus.req0_valid = 1'b0;
        check("sat_data", s_bus.rsp_data, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
